// File: rtl/md_issue_queue.sv
// md_issue_queue: in-order MD issue queue with bypass and HI/LO read interlock.
// Build option MDQ_FLUSH_EN adds a flush port that empties the queue.
module md_issue_queue #(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [3:0]    in_op,
   input  logic [31:0]   in_rs,
   input  logic [31:0]   in_rt,
   output logic          in_ready,
   input  logic          rd_req,
   output logic          stall,
   input  logic          md_busy,
   output logic [3:0]    md_op,
   output logic [31:0]   md_rs,
   output logic [31:0]   md_rt,
`ifdef MDQ_FLUSH_EN
   input  logic          flush,
`endif
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
   } ent_t;

   ent_t          mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic kill;
   logic op_ok;
   logic empty;
   logic push;
   logic issue;
   logic pop;
   logic bypass;
   logic enq;

`ifdef MDQ_FLUSH_EN
   assign kill = flush;
`else
   assign kill = 1'b0;
`endif

   assign op_ok    = (in_op >= 4'd1) && (in_op <= 4'd6);
   assign empty    = (cnt_q == '0);
   assign in_ready = (cnt_q < CW'(DEPTH));
   assign count    = cnt_q;

   assign push   = in_valid & op_ok & in_ready & ~kill & ~reset;
   assign issue  = ~md_busy & ~kill & ~reset & (~empty | push);
   assign pop    = issue & ~empty;
   assign bypass = issue & empty;
   assign enq    = push & ~bypass;

   assign stall = ~kill & ((in_valid & op_ok & ~in_ready) |
                           (rd_req & (~empty | md_busy)));

   always_comb begin
      md_op = 4'd0;
      md_rs = 32'd0;
      md_rt = 32'd0;
      if (pop) begin
         md_op = mem_q[head_q].op;
         md_rs = mem_q[head_q].rs;
         md_rt = mem_q[head_q].rt;
      end else if (bypass) begin
         md_op = in_op;
         md_rs = in_rs;
         md_rt = in_rt;
      end
   end

   // DEPTH is a power of two, so pointers wrap by natural overflow
   always_comb begin
      head_d = pop ? head_q + AW'(1) : head_q;
      tail_d = enq ? tail_q + AW'(1) : tail_q;
      unique case ({enq, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset | kill) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[tail_q] <= '{op: in_op, rs: in_rs, rt: in_rt};
      end
   end

endmodule

// File: tb/tb_md_issue_queue.sv
// Randomized scoreboard bench for md_issue_queue with a behavioural MD unit.
// Set MDQ_FLUSH_EN to also exercise flush.
module tb_md_issue_queue;

   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] rs;
      logic [31:0] rt;
   } item_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic [3:0]    in_op;
   logic [31:0]   in_rs, in_rt;
   logic          in_ready;
   logic          rd_req;
   logic          stall;
   logic          md_busy;
   logic [3:0]    md_op;
   logic [31:0]   md_rs, md_rt;
   logic [CW-1:0] count;
   logic          flush;

   int checks = 0;
   int errors = 0;

   item_t expq[$];
   item_t mon_it;
   bit    armed = 0;
   bit    e_rst, e_fl, e_busy, e_rdy, e_stall;
   int    e_cnt;
   int    bcnt = 0;

   md_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_op(in_op),
      .in_rs(in_rs), .in_rt(in_rt),
      .in_ready(in_ready), .rd_req(rd_req),
      .stall(stall), .md_busy(md_busy),
      .md_op(md_op), .md_rs(md_rs), .md_rt(md_rt),
`ifdef MDQ_FLUSH_EN
      .flush(flush),
`endif
      .count(count)
   );

   always #5 clk = ~clk;

   // The unit: busy 5 cycles after a multiply, 10 after a divide
   assign md_busy = (bcnt != 0);
   always @(posedge clk) begin
      if (md_op == 4'd1 || md_op == 4'd2)      bcnt <= 5;
      else if (md_op == 4'd5 || md_op == 4'd6) bcnt <= 10;
      else if (bcnt > 0)                        bcnt <= bcnt - 1;
   end

   function automatic void chk(string name, logic [31:0] act,
                               logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   task automatic step(input logic v, input logic [3:0] op,
                       input logic [31:0] rs, input logic [31:0] rt,
                       input logic rd, input logic rst, input logic fl);
      bit ok;
      in_valid = v;
      in_op    = op;
      in_rs    = rs;
      in_rt    = rt;
      rd_req   = rd;
      reset    = rst;
      flush    = fl;
      ok       = (op >= 1) && (op <= 6);
      e_busy   = md_busy;
      e_cnt    = expq.size();
      e_rst    = rst;
      e_fl     = fl;
      e_rdy    = (e_cnt < DEPTH);
      e_stall  = fl ? 1'b0 :
                 ((v && ok && !e_rdy) || (rd && (e_cnt != 0 || e_busy)));
      if (rst || fl) expq.delete();
      else if (v && ok && e_rdy) expq.push_back('{op, rs, rt});
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (armed) begin
         if (!e_rst) begin
            if (md_op !== 4'd0) begin
               if (e_fl || e_busy || expq.size() == 0) begin
                  chk("spurious_issue", 32'(md_op), 32'd0);
               end else begin
                  mon_it = expq.pop_front();
                  chk("md_op", 32'(md_op), 32'(mon_it.op));
                  chk("md_rs", md_rs, mon_it.rs);
                  chk("md_rt", md_rt, mon_it.rt);
               end
            end else begin
               chk("idle_rs", md_rs, 32'd0);
               chk("idle_rt", md_rt, 32'd0);
               if (!e_fl && !e_busy && expq.size() != 0)
                  chk("missed_issue", 32'(md_op), 32'(expq[0].op));
            end
         end
         chk("count", 32'(count), 32'(e_cnt));
         if (!e_fl) chk("in_ready", 32'(in_ready), 32'(e_rdy));
         chk("stall", 32'(stall), 32'(e_stall));
      end
   end

   initial begin
      bit v, rd, rst, fl;
      logic [3:0] op;
      step(0, 0, 0, 0, 0, 1, 0);
      armed = 1;
      step(0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // bypass
      step(1, 4'd1, 32'd3, 32'hFFFF_FFFE, 0, 0, 0);
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);
      // queue then drain
      step(1, 4'd5, 32'd7, 32'd2, 0, 0, 0);
      step(1, 4'd2, 32'h1234, 32'h5678, 0, 0, 0);
      step(1, 4'd3, 32'hAAAA, 32'h0, 0, 0, 0);
      step(1, 4'd1, 32'h9, 32'h9, 0, 0, 0);
      step(1, 4'd9, 32'h1, 32'h1, 0, 0, 0);
      // MFHI interlock while draining
      repeat (20) step(0, 0, 0, 0, 1, 0, 0);
      // reset with a full queue and a divide in flight
      step(1, 4'd6, 32'd100, 32'd3, 0, 0, 0);
      step(1, 4'd1, 32'd4, 32'd5, 0, 0, 0);
      step(1, 4'd4, 32'd6, 32'd0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      repeat (12) step(0, 0, 0, 0, 1, 0, 0);
`ifdef MDQ_FLUSH_EN
      step(1, 4'd5, 32'd9, 32'd1, 0, 0, 0);
      step(1, 4'd2, 32'd4, 32'd5, 0, 0, 0);
      step(1, 4'd3, 32'd6, 32'd0, 0, 0, 0);
      step(1, 4'd1, 32'd1, 32'd1, 0, 0, 1);
      repeat (12) step(0, 0, 0, 0, 1, 0, 0);
`endif
      for (int i = 0; i < 3000; i++) begin
         v   = ($urandom_range(0, 9) < 6);
         op  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                           : 4'($urandom_range(1, 6));
         rd  = ($urandom_range(0, 4) == 0);
         rst = ($urandom_range(0, 149) == 0);
`ifdef MDQ_FLUSH_EN
         fl  = ($urandom_range(0, 59) == 0);
`else
         fl  = 1'b0;
`endif
         step(v, op, $urandom, $urandom, rd, rst, fl);
      end
      repeat (15) step(0, 0, 0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
